fc_init_vc_fsm: RTL

Per-VC flow-control initialization engine; sits directly downstream of the InitFC DLLP field decoder. Runs the FC_INIT1 → FC_INIT2 handshake for one virtual channel: it requests transmission of our own InitFC1/InitFC2 sequences and latches the partner's advertised P/NP/Cpl credits from decoded InitFC DLLPs. It also presents scaled credit limits and infinite flags to the transmit credit gate.

---
 rtl/fc_init_vc_fsm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fc_init_vc_fsm.sv
// Per-VC flow-control init engine: runs FC_INIT1/FC_INIT2, requests own
// InitFC DLLPs and latches the partner's scaled P/NP/Cpl credit limits.
module fc_init_vc_fsm #(
    parameter logic [2:0] VC_ID         = 3'd0,
    parameter int         RESEND_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        rx_valid,
    input  logic [1:0]  rx_fc_class,
    input  logic        rx_init2,
    input  logic [2:0]  rx_vc,
    input  logic [1:0]  rx_hdr_scale,
    input  logic [1:0]  rx_data_scale,
    input  logic [7:0]  rx_hdr_fc,
    input  logic [15:0] rx_data_fc,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  tx_class,
    output logic        tx_init2,
    output logic        fc_init_done,
    output logic [11:0] ph_lim,
    output logic [11:0] nph_lim,
    output logic [11:0] cplh_lim,
    output logic [15:0] pd_lim,
    output logic [15:0] npd_lim,
    output logic [15:0] cpld_lim,
    output logic [5:0]  cred_inf
);

    localparam int CW = (RESEND_CYCLES > 2) ? $clog2(RESEND_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(RESEND_CYCLES - 2);

    localparam logic [1:0] CLS_P   = 2'b00;
    localparam logic [1:0] CLS_NP  = 2'b10;
    localparam logic [1:0] CLS_CPL = 2'b11;

    typedef enum logic [1:0] {IDLE, FC_INIT1, FC_INIT2, DONE} state_t;
    typedef enum logic [1:0] {SEQ_START, SEQ_SEND, SEQ_GAP} seq_t;

    state_t          state;
    seq_t            seq;
    logic [CW-1:0]   gap_cnt;
    logic            tx_valid_q;
    logic            cpl_seen;
    logic            fi2;
    logic [2:0]      got;
    logic [2:0]      hinf;
    logic [2:0]      dinf;
    logic [2:0][11:0] hlim;
    logic [2:0][15:0] dlim;

    logic        rx_rel;
    logic [1:0]  rx_idx;
    logic [11:0] rx_hlim;
    logic [15:0] rx_dlim;
    logic        tx_acc;
    logic        cpl_acc;
    logic        unused_data_hi;

    // Scale code to shift amount: 00/01 -> 0, 10 -> 2, 11 -> 4.
    function automatic logic [2:0] shamt(input logic [1:0] s);
        logic [2:0] r;
        r = 3'd0;
        if (s == 2'b10) r = 3'd2;
        if (s == 2'b11) r = 3'd4;
        return r;
    endfunction

    assign unused_data_hi = ^rx_data_fc[15:12];

    // Decode the incoming DLLP: relevance, class slot, scaled limits.
    always_comb begin
        rx_rel  = rx_valid && (rx_fc_class != 2'b01) && (rx_vc == VC_ID);
        rx_idx  = 2'd0;
        unique case (rx_fc_class)
            CLS_NP:  rx_idx = 2'd1;
            CLS_CPL: rx_idx = 2'd2;
            default: rx_idx = 2'd0;
        endcase
        rx_hlim = {4'b0, rx_hdr_fc} << shamt(rx_hdr_scale);
        rx_dlim = {4'b0, rx_data_fc[11:0]} << shamt(rx_data_scale);
    end

    // A dropped link must withdraw the request in the same cycle.
    assign tx_valid = tx_valid_q & link_up;
    assign tx_acc   = tx_valid & tx_ready;
    assign cpl_acc  = tx_acc && (tx_class == CLS_CPL);

    assign ph_lim   = hlim[0];
    assign nph_lim  = hlim[1];
    assign cplh_lim = hlim[2];
    assign pd_lim   = dlim[0];
    assign npd_lim  = dlim[1];
    assign cpld_lim = dlim[2];
    assign cred_inf = {dinf[2], hinf[2], dinf[1], hinf[1], dinf[0], hinf[0]};

    // Main FSM: state, transmit sequencer, credit capture, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            seq          <= SEQ_START;
            gap_cnt      <= '0;
            tx_valid_q   <= 1'b0;
            tx_class     <= CLS_P;
            tx_init2     <= 1'b0;
            fc_init_done <= 1'b0;
            cpl_seen     <= 1'b0;
            fi2          <= 1'b0;
            got          <= '0;
            hinf         <= '0;
            dinf         <= '0;
            hlim         <= '0;
            dlim         <= '0;
        end else if (!link_up) begin
            state        <= IDLE;
            seq          <= SEQ_START;
            gap_cnt      <= '0;
            tx_valid_q   <= 1'b0;
            tx_class     <= CLS_P;
            tx_init2     <= 1'b0;
            fc_init_done <= 1'b0;
            cpl_seen     <= 1'b0;
            fi2          <= 1'b0;
            got          <= '0;
            hinf         <= '0;
            dinf         <= '0;
            hlim         <= '0;
            dlim         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= FC_INIT1;
                    seq      <= SEQ_START;
                    tx_init2 <= 1'b0;
                end
                FC_INIT1, FC_INIT2: begin
                    unique case (seq)
                        SEQ_START: begin
                            tx_valid_q <= 1'b1;
                            tx_class   <= CLS_P;
                            seq        <= SEQ_SEND;
                        end
                        SEQ_SEND: begin
                            if (tx_acc) begin
                                unique case (tx_class)
                                    CLS_P:   tx_class <= CLS_NP;
                                    CLS_NP:  tx_class <= CLS_CPL;
                                    default: begin
                                        tx_valid_q <= 1'b0;
                                        gap_cnt    <= GAP_LOAD;
                                        seq        <= SEQ_GAP;
                                    end
                                endcase
                            end
                        end
                        default: begin
                            if (gap_cnt == '0) begin
                                tx_valid_q <= 1'b1;
                                tx_class   <= CLS_P;
                                seq        <= SEQ_SEND;
                            end else begin
                                gap_cnt <= gap_cnt - CW'(1);
                            end
                        end
                    endcase

                    if (state == FC_INIT1) begin
                        if (rx_rel && !got[rx_idx]) begin
                            got[rx_idx]  <= 1'b1;
                            hlim[rx_idx] <= rx_hlim;
                            dlim[rx_idx] <= rx_dlim;
                            hinf[rx_idx] <= (rx_hdr_fc == 8'd0) &&
                                            (rx_hdr_scale == 2'b00);
                            dinf[rx_idx] <= (rx_data_fc[11:0] == 12'd0) &&
                                            (rx_data_scale == 2'b00);
                        end
                        cpl_seen <= cpl_seen | cpl_acc;
                        if ((&got) && (cpl_seen || cpl_acc)) begin
                            state      <= FC_INIT2;
                            seq        <= SEQ_START;
                            tx_valid_q <= 1'b0;
                            tx_class   <= CLS_P;
                            tx_init2   <= 1'b1;
                            cpl_seen   <= 1'b0;
                        end
                    end else begin
                        if (rx_rel && rx_init2) fi2 <= 1'b1;
                        if (fi2 && (!tx_valid || tx_acc)) begin
                            state        <= DONE;
                            tx_valid_q   <= 1'b0;
                            tx_init2     <= 1'b0;
                            fc_init_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    tx_valid_q   <= 1'b0;
                    fc_init_done <= 1'b1;
                end
            endcase
        end
    end

endmodule
